// File: rtl/sram_seq.sv
// -----------------------------------------------------------------------------
// sram_seq : SRAM access sequencer between the AVR command interface and an
//            external ADDR_W x DATA_W asynchronous SRAM.
//
// The AVR shifts a start address in serially (avr_clk / avr_si, MSB first,
// framed by avr_sreg_en). The falling edge of avr_sreg_en commits it to the
// address counter. Commands then run READ / WRITE cycles with fixed strobe
// timing derived from clk, optionally auto-incrementing the address.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   avr_clk      AVR serial shift clock (asynchronous, synchronised here)
//   avr_si       AVR serial address data, MSB first (synchronised here)
//   avr_sreg_en  AVR shift enable; falling edge commits the shifted address
//   cmd_valid    command strobe, one clk cycle
//   cmd          0 NOP, 1 READ, 2 WRITE, 3 READ_INC, 4 WRITE_INC, 5 INC,
//                6 CLR, 7 NOP
//   wdata        write data, captured when the command is accepted
//   rdata        data from the most recent read
//   busy         a SETUP/STROBE/HOLD sequence is in progress
//   done         one-cycle pulse when a command completes
//   sram_addr    SRAM address (also the address counter)
//   sram_ce_n    SRAM chip enable, active low
//   sram_oe_n    SRAM output enable, active low
//   sram_we_n    SRAM write enable, active low
//   sram_dout    data driven towards the SRAM
//   sram_dout_en tri-state enable for sram_dout
//   sram_din     data returned by the SRAM
//   state_dbg    current FSM state (IDLE=0, SETUP=1, STROBE=2, HOLD=3)
//
// Command handshake: there is no separate ready signal. A command is taken
// in the cycle cmd_valid is high while busy is low (FSM in IDLE); NOP codes
// are never taken. A cmd_valid seen while busy is dropped, never queued.
// Access commands raise busy the next cycle and pulse done STROBE_CYC + 3
// cycles after cmd_valid; INC and CLR finish in place and pulse done the
// next cycle with busy left low.
// -----------------------------------------------------------------------------
module sram_seq #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avr_clk,
    input  logic              avr_si,
    input  logic              avr_sreg_en,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din,
    output logic [1:0]        state_dbg
);

    // Command encodings
    localparam logic [2:0] CMD_NOP0      = 3'd0;
    localparam logic [2:0] CMD_READ      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_INC  = 3'd3;
    localparam logic [2:0] CMD_WRITE_INC = 3'd4;
    localparam logic [2:0] CMD_INC       = 3'd5;
    localparam logic [2:0] CMD_CLR       = 3'd6;
    localparam logic [2:0] CMD_NOP7      = 3'd7;

    localparam logic [3:0]        STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] strobe_cnt;
    logic [3:0] strobe_cnt_nxt;

    // -------------------------------------------------------------------------
    // AVR input synchronisers and edge detection
    // -------------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] si_sync;
    logic [1:0] en_sync;
    logic       clk_prev;
    logic       en_prev;
    logic       avr_clk_rise;
    logic       sreg_en_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= '0;
            si_sync  <= '0;
            en_sync  <= '0;
            clk_prev <= 1'b0;
            en_prev  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], avr_clk};
            si_sync  <= {si_sync[0], avr_si};
            en_sync  <= {en_sync[0], avr_sreg_en};
            clk_prev <= clk_sync[1];
            en_prev  <= en_sync[1];
        end
    end

    // avr_si travels through the same two-flop depth as avr_clk, so the data
    // bit seen here lines up with the clock edge the AVR produced.
    assign avr_clk_rise = clk_sync[1] & ~clk_prev;
    assign sreg_en_fall = en_prev & ~en_sync[1];

    // -------------------------------------------------------------------------
    // Serial address shift register and pending commit
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] shift_q;
    logic              pending;
    logic              commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
        end else if (avr_clk_rise && en_sync[1]) begin
            // Bits beyond ADDR_W simply fall off the MSB end.
            shift_q <= {shift_q[ADDR_W-2:0], si_sync[1]};
        end
    end

    // A commit is only applied in IDLE so the address never moves under an
    // active SRAM cycle; otherwise it waits here.
    assign commit = pending && (state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            // A fresh falling edge wins over a same-cycle commit so the newer
            // shift register contents are applied on the following cycle.
            pending <= (pending && !commit) || sreg_en_fall;
        end
    end

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic [2:0] cmd_q;
    logic       cmd_is_nop;
    logic       cmd_is_access;
    logic       accept;
    logic [2:0] cur_cmd;
    logic       cur_is_write;
    logic       q_is_write;
    logic       q_is_inc;
    logic       strobe_last;

    assign cmd_is_nop    = (cmd == CMD_NOP0) || (cmd == CMD_NOP7);
    assign cmd_is_access = (cmd == CMD_READ)     || (cmd == CMD_WRITE) ||
                           (cmd == CMD_READ_INC) || (cmd == CMD_WRITE_INC);
    assign accept        = cmd_valid && !cmd_is_nop && (state == S_IDLE);

    // The registered SRAM controls are computed one cycle ahead, so on the
    // accepting edge the incoming cmd decides read vs write, afterwards the
    // latched copy does.
    assign cur_cmd      = accept ? cmd : cmd_q;
    assign cur_is_write = (cur_cmd == CMD_WRITE) || (cur_cmd == CMD_WRITE_INC);
    assign q_is_write   = (cmd_q == CMD_WRITE) || (cmd_q == CMD_WRITE_INC);
    assign q_is_inc     = (cmd_q == CMD_READ_INC) || (cmd_q == CMD_WRITE_INC);
    assign strobe_last  = (strobe_cnt == STROBE_LAST);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            strobe_cnt <= '0;
        end else begin
            state      <= state_nxt;
            strobe_cnt <= strobe_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        strobe_cnt_nxt = strobe_cnt;
        case (state)
            S_IDLE: begin
                if (accept && cmd_is_access) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt      = S_STROBE;
                strobe_cnt_nxt = '0;
            end
            S_STROBE: begin
                if (strobe_last) begin
                    state_nxt = S_HOLD;
                end else begin
                    strobe_cnt_nxt = strobe_cnt + 4'd1;
                end
            end
            S_HOLD: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Address counter next value
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] addr_nxt;

    // A command accepted together with a commit operates on the new address.
    assign base_addr = commit ? shift_q : sram_addr;

    always_comb begin
        addr_nxt = base_addr;
        if (accept && (cmd == CMD_INC)) begin
            addr_nxt = base_addr + ADDR_ONE;   // wraps modulo 2^ADDR_W
        end else if (accept && (cmd == CMD_CLR)) begin
            addr_nxt = '0;
        end else if ((state == S_HOLD) && q_is_inc) begin
            addr_nxt = sram_addr + ADDR_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    // Every SRAM-facing signal comes straight from a flop, so strobes cannot
    // glitch. oe_n and we_n are both derived from the same read/write decode,
    // so they can never be low together, and dout_en is never set on a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q        <= CMD_NOP0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rdata        <= '0;
            sram_addr    <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_dout    <= '0;
            sram_dout_en <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= cmd;
            end
            if (accept && ((cmd == CMD_WRITE) || (cmd == CMD_WRITE_INC))) begin
                sram_dout <= wdata;
            end

            sram_addr    <= addr_nxt;
            busy         <= (state_nxt != S_IDLE);
            done         <= (state == S_HOLD) ||
                            (accept && ((cmd == CMD_INC) || (cmd == CMD_CLR)));

            sram_ce_n    <= (state_nxt == S_IDLE);
            sram_oe_n    <= !((state_nxt == S_STROBE) && !cur_is_write);
            sram_we_n    <= !((state_nxt == S_STROBE) && cur_is_write);
            sram_dout_en <= (state_nxt != S_IDLE) && cur_is_write;

            // Capture at the end of the last strobe cycle, when the SRAM
            // output has had the full strobe window to settle.
            if ((state == S_STROBE) && strobe_last && !q_is_write) begin
                rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_seq.sv
// -----------------------------------------------------------------------------
// tb_sram_seq : directed self-checking bench for sram_seq.
// Read data comes from a fixed address-dependent SRAM model, so the expected
// rdata of each read is pushed when the read is issued and popped when the
// DUT pulses done.
// -----------------------------------------------------------------------------
module tb_sram_seq;

    localparam int ADDR_W     = 21;
    localparam int DATA_W     = 8;
    localparam int STROBE_CYC = 2;

    localparam logic [2:0] CMD_READ      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_INC  = 3'd3;
    localparam logic [2:0] CMD_WRITE_INC = 3'd4;
    localparam logic [2:0] CMD_INC       = 3'd5;
    localparam logic [2:0] CMD_CLR       = 3'd6;

    // ---------------------------------------------------------------- signals
    logic              clk = 1'b0;
    logic              reset;
    logic              avr_clk;
    logic              avr_si;
    logic              avr_sreg_en;
    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_dout_en;
    logic [DATA_W-1:0] sram_din;
    logic [1:0]        state_dbg;

    // ------------------------------------------------------------ bookkeeping
    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];

    int ce_cnt, oe_cnt, we_cnt, den_cnt, busy_cnt, done_cyc, dout_bad;
    int inv_bad = 0;
    logic [ADDR_W-1:0] addr_hist[0:15];

    // SRAM model: contents are a fixed function of the address.
    function automatic logic [DATA_W-1:0] din_model(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h4B;
    endfunction

    assign sram_din = din_model(sram_addr);

    // ---------------------------------------------------------- clock / reset
    always #5 clk = ~clk;

    sram_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STROBE_CYC (STROBE_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avr_clk      (avr_clk),
        .avr_si       (avr_si),
        .avr_sreg_en  (avr_sreg_en),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .wdata        (wdata),
        .rdata        (rdata),
        .busy         (busy),
        .done         (done),
        .sram_addr    (sram_addr),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_dout    (sram_dout),
        .sram_dout_en (sram_dout_en),
        .sram_din     (sram_din),
        .state_dbg    (state_dbg)
    );

    // ----------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hist_const(input int lo, input int hi, input logic [ADDR_W-1:0] val);
        logic ok;
        ok = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            if (addr_hist[i] !== val) ok = 1'b0;
        end
        return ok;
    endfunction

    // ----------------------------------------------------------------- driver
    // Shift n bits of val MSB first, leaving avr_sreg_en high.
    task automatic shift_bits(input logic [31:0] val, input int n);
        avr_sreg_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            avr_si = val[i];
            repeat (3) @(negedge clk);
            avr_clk = 1'b1;
            repeat (3) @(negedge clk);
            avr_clk = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic commit_addr();
        avr_sreg_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Issue one command at the current negedge and watch the SRAM pins for up
    // to 12 cycles (cycle k = k rising edges after cmd_valid was sampled).
    // drop_at: cycle to drop avr_sreg_en; poke_at: cycle to pulse a CLR.
    task automatic run_cmd(input logic [2:0] c, input logic [7:0] wd,
                           input int drop_at, input int poke_at);
        logic is_read;
        is_read  = (c == CMD_READ) || (c == CMD_READ_INC);
        ce_cnt   = 0; oe_cnt = 0; we_cnt = 0; den_cnt = 0;
        busy_cnt = 0; done_cyc = 0; dout_bad = 0;
        for (int i = 0; i < 16; i++) addr_hist[i] = '0;
        cmd       = c;
        wdata     = wd;
        cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (done_cyc != 0 && cyc > done_cyc + 2) break;
            @(negedge clk);
            addr_hist[cyc] = sram_addr;
            if (!sram_ce_n)   ce_cnt++;
            if (!sram_oe_n)   oe_cnt++;
            if (!sram_we_n)   we_cnt++;
            if (sram_dout_en) den_cnt++;
            if (busy)         busy_cnt++;
            if (!sram_we_n && sram_dout !== wd) dout_bad++;
            if (!sram_oe_n && !sram_we_n)       inv_bad++;
            if (!sram_oe_n && sram_dout_en)     inv_bad++;
            if (done && done_cyc == 0) begin
                done_cyc = cyc;
                if (is_read) begin
                    check("sb_depth", 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() != 0) check("rdata", rdata, exp_q.pop_front());
                end
            end
            if (cyc == 1) cmd_valid = 1'b0;
            if (cyc == poke_at) begin
                cmd       = CMD_CLR;
                cmd_valid = 1'b1;
            end else if (poke_at != 0 && cyc == poke_at + 1) begin
                cmd_valid = 1'b0;
            end
            if (cyc == drop_at) avr_sreg_en = 1'b0;
        end
        cmd_valid = 1'b0;
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        reset       = 1'b0;
        avr_clk     = 1'b0;
        avr_si      = 1'b0;
        avr_sreg_en = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = 3'd0;
        wdata       = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_dout", {sram_dout, sram_dout_en}, 9'h000);
        check("rst_state", state_dbg, 0);
        reset = 1'b1;
        @(negedge clk);

        // Serial load: 21 bits, commit lands within 4 clk of the falling edge
        shift_bits(32'h012345, 21);
        commit_addr();
        check("load21_addr", sram_addr, 21'h012345);
        check("load21_busy", busy, 0);

        // 22 bits: the first bit falls off the MSB end
        shift_bits(32'h2ABCDE, 22);
        commit_addr();
        check("load22_addr", sram_addr, 21'h0ABCDE);

        // WRITE_INC 0xA5 at 0x10
        shift_bits(32'h10, 21);
        commit_addr();
        check("wr_start_addr", sram_addr, 21'h10);
        run_cmd(CMD_WRITE_INC, 8'hA5, 0, 0);
        check("wr_ce_cycles", ce_cnt, 4);
        check("wr_we_cycles", we_cnt, STROBE_CYC);
        check("wr_oe_cycles", oe_cnt, 0);
        check("wr_den_cycles", den_cnt, 4);
        check("wr_busy_cycles", busy_cnt, 4);
        check("wr_done_cycle", done_cyc, STROBE_CYC + 3);
        check("wr_dout", dout_bad, 0);
        check("wr_addr_stable", hist_const(1, 4, 21'h10), 1);
        check("wr_addr_inc", addr_hist[5], 21'h11);

        // READ at 0x11
        exp_q.push_back(din_model(21'h11));
        run_cmd(CMD_READ, 8'h00, 0, 0);
        check("rd_oe_cycles", oe_cnt, STROBE_CYC);
        check("rd_we_cycles", we_cnt, 0);
        check("rd_den_cycles", den_cnt, 0);
        check("rd_ce_cycles", ce_cnt, 4);
        check("rd_done_cycle", done_cyc, STROBE_CYC + 3);
        check("rd_addr_same", hist_const(1, 7, 21'h11), 1);

        // READ_INC at 0x11 -> 0x12
        exp_q.push_back(din_model(21'h11));
        run_cmd(CMD_READ_INC, 8'h00, 0, 0);
        check("rdi_done_cycle", done_cyc, STROBE_CYC + 3);
        check("rdi_addr_inc", addr_hist[5], 21'h12);

        // INC wraps at the top of the address space
        shift_bits(32'h1FFFFF, 21);
        commit_addr();
        check("wrap_start", sram_addr, 21'h1FFFFF);
        run_cmd(CMD_INC, 8'h00, 0, 0);
        check("inc_wrap_addr", addr_hist[1], 21'h000000);
        check("inc_done_cycle", done_cyc, 1);
        check("inc_busy", busy_cnt, 0);
        check("inc_ce", ce_cnt, 0);
        run_cmd(CMD_INC, 8'h00, 0, 0);
        check("inc2_addr", addr_hist[1], 21'h000001);

        // CLR
        run_cmd(CMD_CLR, 8'h00, 0, 0);
        check("clr_addr", addr_hist[1], 21'h000000);
        check("clr_done_cycle", done_cyc, 1);
        check("clr_busy", busy_cnt, 0);

        // Commit arriving during a READ plus a CLR pulsed while busy
        shift_bits(32'h33, 21);
        commit_addr();
        shift_bits(32'h55, 21);
        exp_q.push_back(din_model(21'h33));
        run_cmd(CMD_READ, 8'h00, 1, 2);
        check("cmt_done_cycle", done_cyc, STROBE_CYC + 3);
        check("cmt_busy_cycles", busy_cnt, 4);
        check("cmt_old_addr", hist_const(1, 5, 21'h33), 1);
        check("cmt_new_addr", addr_hist[6], 21'h55);

        // Reset during the STROBE phase of a WRITE
        cmd       = CMD_WRITE;
        wdata     = 8'h3C;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rstw_in_strobe", {sram_we_n, sram_ce_n, sram_dout_en}, 3'b001);
        #2 reset = 1'b0;
        #1;
        check("rstw_async", {sram_we_n, sram_ce_n, sram_oe_n, sram_dout_en}, 4'b1110);
        check("rstw_addr", sram_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rstw_state", state_dbg, 0);
        check("rstw_busy", {busy, done}, 2'b00);

        // Sequencer is usable again after reset
        exp_q.push_back(din_model(21'h0));
        run_cmd(CMD_READ, 8'h00, 0, 0);
        check("post_rst_done", done_cyc, STROBE_CYC + 3);

        check("invariants", inv_bad, 0);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
